// File: rtl/pt8211_pkg.sv
// rtl/pt8211_pkg.sv - shared types and frame geometry for the PT8211 link
package pt8211_pkg;

    localparam int FRAME_BITS = 32;
    localparam int SLOT_BITS  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [SLOT_BITS-1:0] left;
        logic [SLOT_BITS-1:0] right;
    } frame_t;

endpackage

// File: rtl/pt8211_frame_fifo.sv
// rtl/pt8211_frame_fifo.sv - show-ahead stereo frame FIFO with level output
module pt8211_frame_fifo
    import pt8211_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  frame_t                 push_data_i,
    input  logic                   pop_i,
    output frame_t                 pop_data_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    frame_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign full_o     = (level_q == (AW+1)'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign level_o    = level_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/pt8211_frame_scheduler.sv
// rtl/pt8211_frame_scheduler.sv - buffers stereo frames and serialises them onto the PT8211 pins
module pt8211_frame_scheduler
    import pt8211_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_W-1:0]           s_left,
    input  logic [DATA_W-1:0]           s_right,
    input  logic                        underrun_clr,
    output logic                        bck,
    output logic                        ws,
    output logic                        din,
    output logic                        frame_tick,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    state_t                state_q;
    logic [7:0]            div_cnt_q;
    logic [4:0]            bit_cnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic                  bck_q;
    logic                  ws_q;
    logic                  din_q;
    logic                  tick_q;
    logic                  underrun_q;

    frame_t                push_frame;
    frame_t                pop_frame;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  div_tc;
    logic                  bck_fall;
    logic                  frame_end;
    logic                  do_load;
    logic [FRAME_BITS-1:0] load_word;

    assign push_frame = '{left: s_left, right: s_right};
    assign fifo_push  = s_valid && !fifo_full;
    assign s_ready    = !fifo_full;

    assign div_tc    = (div_cnt_q == 8'(CLK_DIV - 1));
    assign bck_fall  = (state_q == RUN) && div_tc && bck_q;
    assign frame_end = bck_fall && (bit_cnt_q == 5'(FRAME_BITS - 1));
    assign do_load   = enable && ((state_q == IDLE) || frame_end);
    assign fifo_pop  = do_load && !fifo_empty;
    // An empty FIFO at load time sends silence rather than stalling the link.
    assign load_word = fifo_empty ? '0 : {pop_frame.left, pop_frame.right};

    pt8211_frame_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_data_i(push_frame),
        .pop_i      (fifo_pop),
        .pop_data_o (pop_frame),
        .level_o    (fifo_level),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            bck_q      <= 1'b0;
            ws_q       <= 1'b0;
            din_q      <= 1'b0;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    bck_q     <= 1'b0;
                    div_cnt_q <= '0;
                end
                RUN: begin
                    if (div_tc) begin
                        div_cnt_q <= '0;
                        bck_q     <= ~bck_q;
                        // Data and word select only move on the falling edge of bck.
                        if (bck_q) begin
                            if (frame_end) begin
                                if (!enable) begin
                                    state_q <= DRAIN;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                                shift_q   <= shift_q << 1;
                                din_q     <= shift_q[FRAME_BITS-2];
                                if (bit_cnt_q == 5'(SLOT_BITS - 1)) begin
                                    ws_q <= 1'b0;
                                end
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    bck_q     <= 1'b0;
                    din_q     <= 1'b0;
                    ws_q      <= 1'b0;
                    div_cnt_q <= '0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Loading overrides the per-state updates so back-to-back frames have no gap.
            if (do_load) begin
                shift_q   <= load_word;
                din_q     <= load_word[FRAME_BITS-1];
                ws_q      <= 1'b1;
                bck_q     <= 1'b0;
                bit_cnt_q <= '0;
                div_cnt_q <= '0;
                tick_q    <= 1'b1;
                state_q   <= RUN;
            end

            if (do_load && fifo_empty) begin
                underrun_q <= 1'b1;
            end else if (underrun_clr) begin
                underrun_q <= 1'b0;
            end
        end
    end

    assign bck        = bck_q;
    assign ws         = ws_q;
    assign din        = din_q;
    assign frame_tick = tick_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_pt8211_frame_scheduler.sv
// tb/tb_pt8211_frame_scheduler.sv - self-checking bench for pt8211_frame_scheduler
`timescale 1ns/1ps
module tb_pt8211_frame_scheduler;
    localparam int CLK_DIV = 2;
    localparam int DEPTH   = 4;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [15:0]   s_left = '0;
    logic [15:0]   s_right = '0;
    logic          underrun_clr = 1'b0;
    logic          bck, ws, din, frame_tick, underrun;
    logic [LW-1:0] fifo_level;

    always #5 clk = ~clk;

    pt8211_frame_scheduler #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(DEPTH),
        .DATA_W    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_left      (s_left),
        .s_right     (s_right),
        .underrun_clr(underrun_clr),
        .bck         (bck),
        .ws          (ws),
        .din         (din),
        .frame_tick  (frame_tick),
        .underrun    (underrun),
        .fifo_level  (fifo_level)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: queue of accepted frames, expected serial frame, sticky flag.
    logic [31:0] mdl_q[$];
    logic        exp_underrun = 1'b0;
    logic [31:0] exp_frame = '0;
    logic [31:0] cap_frame = '0;
    logic [31:0] last_frame = '0;
    int          bit_idx = 0;
    bit          frame_active = 1'b0;
    int          cyc = 0, tick_cyc = 0, rise_cyc = 0, fall_cyc = -1, ticks = 0;
    logic        prev_bck = 1'b0;

    always @(posedge clk) begin
        int  pre_sz;
        bit  was_empty;
        #1;
        cyc++;
        if (rst) begin
            mdl_q.delete();
            exp_underrun = 1'b0;
            frame_active = 1'b0;
            bit_idx      = 0;
            prev_bck     = 1'b0;
        end else begin
            pre_sz    = mdl_q.size();
            was_empty = (pre_sz == 0);
            if (!bck && prev_bck) fall_cyc = cyc;
            if (frame_tick) begin
                ticks++;
                if (frame_active) begin
                    check_eq("frame_len", bit_idx, 32);
                    if (fall_cyc == cyc) check_eq("frame_period", cyc - tick_cyc, 64 * CLK_DIV);
                end
                exp_frame    = was_empty ? 32'h0 : mdl_q.pop_front();
                frame_active = 1'b1;
                bit_idx      = 0;
                tick_cyc     = cyc;
                cap_frame    = '0;
            end
            if (frame_tick && was_empty) exp_underrun = 1'b1;
            else if (underrun_clr) exp_underrun = 1'b0;
            if (s_valid && pre_sz < DEPTH) mdl_q.push_back({s_left, s_right});

            check_eq("fifo_level", fifo_level, mdl_q.size());
            check_eq("s_ready", s_ready, mdl_q.size() != DEPTH);
            check_eq("underrun", underrun, exp_underrun);

            if (bck && !prev_bck) begin
                check_eq("bck_in_frame", frame_active && bit_idx < 32, 1);
                if (frame_active && bit_idx < 32) begin
                    if (bit_idx == 0) check_eq("first_rise", cyc - tick_cyc, CLK_DIV);
                    else              check_eq("bck_period", cyc - rise_cyc, 2 * CLK_DIV);
                    check_eq("ws_bit", ws, bit_idx < 16);
                    check_eq("din_bit", din, exp_frame[31 - bit_idx]);
                    cap_frame[31 - bit_idx] = din;
                    bit_idx++;
                    if (bit_idx == 32) last_frame = cap_frame;
                end
                rise_cyc = cyc;
            end
            prev_bck = bck;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_tick(input string tag, input int budget);
        int t0 = ticks;
        int i  = 0;
        while (ticks == t0 && i < budget) begin
            step();
            i++;
        end
        check_eq({tag, "_tick_timeout"}, ticks != t0, 1);
    endtask

    task automatic wait_bits(input string tag, input int target, input int budget);
        int i = 0;
        while (!(frame_active && bit_idx >= target) && i < budget) begin
            step();
            i++;
        end
        check_eq({tag, "_bits_timeout"}, frame_active && bit_idx >= target, 1);
    endtask

    task automatic push_one(input logic [15:0] l, input logic [15:0] r);
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_start;
        step(2);
        check_eq("rst_bck", bck, 0);
        check_eq("rst_ws", ws, 0);
        check_eq("rst_din", din, 0);
        check_eq("rst_tick", frame_tick, 0);
        check_eq("rst_underrun", underrun, 0);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_ready", s_ready, 1);
        rst = 1'b0;
        step(2);

        // Single known frame, enable dropped right after the load.
        t_start = ticks;
        push_one(16'hA5C3, 16'h1234);
        check_eq("one_level", fifo_level, 1);
        enable = 1'b1;
        wait_tick("known", 10);
        enable = 1'b0;
        check_eq("known_pop_level", fifo_level, 0);
        check_eq("known_ws_load", ws, 1);
        wait_bits("known", 32, 300);
        step(6);
        check_eq("known_frame", last_frame, 32'hA5C31234);
        check_eq("known_ticks", ticks - t_start, 1);
        check_eq("known_idle_bck", bck, 0);
        check_eq("known_idle_ws", ws, 0);

        // Load from empty: zero frame and sticky underrun.
        enable = 1'b1;
        wait_tick("empty", 10);
        enable = 1'b0;
        check_eq("empty_underrun", underrun, 1);
        wait_bits("empty", 32, 300);
        step(6);
        check_eq("empty_frame", last_frame, 32'h0);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check_eq("underrun_cleared", underrun, 0);
        enable = 1'b1;
        underrun_clr = 1'b1;
        wait_tick("setclr", 10);
        underrun_clr = 1'b0;
        enable = 1'b0;
        check_eq("set_wins", underrun, 1);
        wait_bits("setclr", 32, 300);
        step(6);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;

        // Fill to full while idle, then stream the queue back to back.
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_left  = 16'($urandom);
            s_right = 16'($urandom);
            step();
        end
        check_eq("full_level", fifo_level, DEPTH);
        check_eq("full_ready", s_ready, 0);
        enable = 1'b1;
        wait_tick("full", 10);
        check_eq("pop_ready_next", s_ready, 1);
        check_eq("pop_level", fifo_level, DEPTH - 1);
        s_valid = 1'b0;
        for (int f = 0; f < DEPTH - 1; f++) begin
            wait_tick("stream", 200);
            check_eq("stream_no_underrun", underrun, 0);
        end
        t_start = cyc;
        wait_tick("starve", 200);
        check_eq("starve_interval", cyc - t_start <= 64 * CLK_DIV, 1);
        check_eq("starve_underrun", underrun, 1);
        wait_bits("drop", 5, 100);
        enable = 1'b0;
        wait_bits("drop_end", 32, 300);
        step(2 * CLK_DIV + 2);
        check_eq("drain_bck", bck, 0);
        check_eq("drain_ws", ws, 0);
        check_eq("drain_din", din, 0);
        t_start = ticks;
        step(200);
        check_eq("no_more_ticks", ticks - t_start, 0);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;

        // Randomised streaming against the model.
        enable = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            s_valid      = ($urandom % 3) != 0;
            s_left       = 16'($urandom);
            s_right      = 16'($urandom);
            underrun_clr = ($urandom % 64) == 0;
            step();
        end
        s_valid = 1'b0;
        underrun_clr = 1'b0;

        // Asynchronous reset in the middle of a frame.
        wait_bits("rst_mid", 20, 300);
        rst = 1'b1;
        enable = 1'b0;
        #1;
        check_eq("mid_rst_bck", bck, 0);
        check_eq("mid_rst_ws", ws, 0);
        check_eq("mid_rst_din", din, 0);
        check_eq("mid_rst_level", fifo_level, 0);
        check_eq("mid_rst_underrun", underrun, 0);
        step(2);
        rst = 1'b0;
        step(2);
        push_one(16'h8001, 16'h7FFE);
        enable = 1'b1;
        wait_tick("resume", 10);
        enable = 1'b0;
        wait_bits("resume", 32, 300);
        step(6);
        check_eq("resume_frame", last_frame, 32'h80017FFE);
        check_eq("resume_underrun", underrun, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pt8211_frame_scheduler.md
Name: pt8211_frame_scheduler

Overview:
- System-clock-domain controller that owns the PT8211 serial link.
- Buffers stereo sample frames from the audio source in a small FIFO and derives the bit clock by division.
- Schedules each 32-bit frame: WS-high slot carries left[15:0] MSB-first, WS-low slot carries right[15:0] MSB-first.
- Flags underruns. Sits between the synthesis/mixer output and the DAC pins.

Parameters:
CLK_DIV, 4, system clocks per bck half-period; legal range 2..255
FIFO_DEPTH, 4, stereo frames buffered; power of two, 2..16
DATA_W, 16, bits per channel sample; fixed to 16 for the PT8211

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  run request; sampled on clk
s_valid  in  1  source frame valid
s_ready  out  1  FIFO can accept a frame
s_left  in  16  left sample, two's complement
s_right  in  16  right sample, two's complement
underrun_clr  in  1  clears the sticky underrun flag
bck  out  1  DAC bit clock
ws  out  1  DAC word select
din  out  1  DAC serial data
frame_tick  out  1  one-clk pulse when a frame is loaded
underrun  out  1  sticky: a frame was loaded from an empty FIFO
fifo_level  out  $clog2(FIFO_DEPTH)+1  frames currently buffered

Behaviour:
- Reset (async, rst=1): bck=0, ws=0, din=0, frame_tick=0, underrun=0, FIFO empty (fifo_level=0, s_ready=1), state=IDLE, div_cnt=0, bit_cnt=0.
- Source handshake:
  - Push occurs when s_valid & s_ready on a rising clk.
  - s_ready = (fifo_level != FIFO_DEPTH), registered count only. A pop in the same cycle does not raise s_ready.
  - Push and pop in the same cycle are both honoured; fifo_level is unchanged.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - bck held 0, ws and din hold their last values, div_cnt=0.
  - enable=1 -> LOAD action, then RUN.
- LOAD action (a registered edge):
  - If the FIFO is non-empty, pop into shift_reg = {left,right}.
  - Otherwise shift_reg = 32'h0 and underrun <= 1.
  - Same edge: ws<=1, din<=shift_reg[31] value being loaded, bit_cnt<=0, frame_tick=1 for that one cycle.
- RUN, bck generation:
  - div_cnt counts 0..CLK_DIV-1; at terminal count it wraps and bck toggles.
  - Period of bck = 2*CLK_DIV clks, 50% duty. First rising edge CLK_DIV clks after LOAD.
- Falling edge of bck (bck 1->0 toggle), bit_cnt 0..30:
  - bit_cnt increments; din <= next bit.
  - When bit_cnt becomes 16: ws<=0 and din<=right[15].
  - ws and din change only on this edge, so they are stable at each bck rise.
- Falling edge of bck, bit_cnt==31 (frame end):
  - If enable=1: LOAD action on the same edge. No gap between frames; frame period = 64*CLK_DIV clks.
  - If enable=0: go to DRAIN.
- DRAIN: bck stays 0, din<=0, ws<=0, then IDLE. enable deasserted mid-frame always completes the current frame.
- underrun: set on a LOAD from empty. underrun_clr clears it; if set and clear coincide, set wins.
- FIFO contents are preserved across IDLE; only rst flushes them.
- fifo_level wraps never: push is blocked when full; pop from empty is replaced by zero-load.
- Reset asserted mid-frame: all outputs return to reset values immediately (async); the frame is discarded.

Decomposition:
- pt8211_pkg:
  - FRAME_BITS=32, SLOT_BITS=16.
  - State enum {IDLE, RUN, DRAIN}.
  - Frame typedef (struct left/right, 16 bits each).
- Sub-module: pt8211_frame_fifo. Synchronous FIFO, 32-bit wide, FIFO_DEPTH deep, with level output and async active-high rst.
- The scheduler instantiates it and contains the divider, bit counter, shift register and FSM.

Test Plan:
- CLK_DIV=2, push one frame L=16'hA5C3, R=16'h1234, then enable=1:
  - frame_tick fires once; ws=1 for 16 bck periods while din shows 1010010111000011, then ws=0 while din shows 0001001000110100.
  - bck period is 4 clks; fifo_level goes 1->0.
- Enable with FIFO empty -> frame of 32 zero bits, underrun=1. Assert underrun_clr -> underrun=0. Set and clear in the same cycle -> stays 1.
- Hold s_valid=1 with enable=0, FIFO_DEPTH=4 -> exactly 4 pushes accepted, s_ready=0, fifo_level=4. Then enable: first pop does not assert s_ready until the next cycle.
- Drop enable at bit_cnt=5 -> frame completes through bit 31, then DRAIN gives bck=0, ws=0, din=0, then IDLE. No further pops.
- Continuous streaming with 3 queued frames -> back-to-back frames, frame_tick every 128 clks at CLK_DIV=2, no underrun. Then underrun=1 on the 4th frame if no push arrives.
- Assert rst at bit_cnt=20 -> bck=ws=din=0 and fifo_level=0 immediately. Resumes cleanly from IDLE after rst is released.
